draw_arbiter: RTL and testbench
===============================

DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 4096, is the number of BUSY cycles allowed without draw_done before the grant is aborted.
REQ-002 Parameter X_W, default 9, is the X coordinate width for 320-pixel resolution.
REQ-003 Parameter Y_W, default 8, is the Y coordinate width for 240-pixel resolution.
REQ-004 clock  input  1  is the single clock; all state changes occur on its rising edge.
REQ-005 reset  input  1  is an asynchronous, active-high reset.
REQ-006 req  input  3  carries level requests: bit0 background restore, bit1 character, bit2 moving platform.
REQ-007 req_x  input  3*X_W  carries the per-requester X coordinate; requester k occupies slice [k*X_W +: X_W].
REQ-008 req_y  input  3*Y_W  carries the per-requester Y coordinate, sliced like req_x.
REQ-009 grant  output  3  is the one-hot owner of the sprite drawer.
REQ-010 ack  output  3  is a one-hot, 1-cycle completion pulse to the granted requester.
REQ-011 err  output  1  is valid with ack; 1 means the draw timed out.
REQ-012 busy  output  1  is 1 whenever the state is not IDLE.
REQ-013 draw_start  output  1  is a 1-cycle start pulse to the sprite drawer.
REQ-014 draw_sel  output  2  is the granted requester index and selects the sprite/background source.
REQ-015 draw_x / draw_y  output  X_W / Y_W  are the latched coordinates of the granted requester.
REQ-016 draw_done  input  1  is the drawer completion indication, a pulse or level.

Function
REQ-017 The FSM SHALL have four states: IDLE, ISSUE, BUSY and DONE.
REQ-018 IDLE: if any req bit is 1, the arbiter SHALL pick a winner, latch its index, req_x and req_y, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-019 ISSUE: draw_start=1 for exactly this cycle, then the FSM SHALL go to BUSY; draw_done SHALL be ignored in ISSUE.
REQ-020 BUSY: on draw_done=1 the FSM SHALL go to DONE with err=0; when the timeout counter reaches TIMEOUT-1 without draw_done it SHALL go to DONE with err=1.
REQ-021 DONE: ack[winner]=1 for exactly this cycle, then the FSM SHALL return to IDLE.
REQ-022 grant[winner] SHALL be 1 throughout ISSUE, BUSY and DONE, and 0 in IDLE.
REQ-023 draw_sel, draw_x and draw_y SHALL stay stable from ISSUE through DONE; req_x/req_y changes during that window SHALL be ignored.
REQ-024 A requester SHALL drop req on the edge following ack; the arbiter samples req only in IDLE.
REQ-025 A requester that holds req past that edge SHALL be re-arbitrated as a new request.
REQ-026 The minimum request-to-ack latency SHALL be 3 cycles (IDLE, ISSUE, BUSY with draw_done, DONE asserting ack), with at least 1 IDLE cycle between consecutive grants.
REQ-027 The timeout counter SHALL clear on entry to ISSUE, increment in BUSY, and saturate (never wrap).
REQ-028 A req deasserted mid-grant SHALL NOT abort the grant; the draw completes and ack is still issued.
REQ-029 If draw_done and the timeout occur in the same cycle, draw_done SHALL win and err SHALL be 0.

Reset
REQ-030 While reset=1: state=IDLE; grant, ack, err, busy and draw_start are 0; draw_sel, draw_x, draw_y and the counter are 0; the round-robin pointer is 0.
REQ-031 Reset asserted mid-operation SHALL abandon the grant with no ack; the sprite drawer SHALL share the same reset.

Configuration
REQ-032 With DRAW_ARB_ROUND_ROBIN_EN defined, winner selection SHALL be round-robin: search starts at (last winner + 1) mod 3, and the pointer updates on DONE.
REQ-033 Without DRAW_ARB_ROUND_ROBIN_EN, winner selection SHALL be fixed priority: bit0 > bit1 > bit2, with no pointer register.

Structure
REQ-034 Package draw_arb_pkg SHALL hold the state encoding, the requester index constants (REQ_BG=0, REQ_CHAR=1, REQ_PLAT=2) and the default TIMEOUT.
REQ-035 A combinational sub-module draw_arb_picker(req, ptr -> winner index, valid) SHALL contain both selection policies under the macro.

Verification
REQ-036 req=3'b010, req_x[1]=95, req_y[1]=221, draw_done 5 cycles after draw_start -> draw_sel=1, draw_x=95, draw_y=221, ack=3'b010, err=0.
REQ-037 req=3'b111 held, fixed priority -> grant sequence 001, 010, 100 as each requester drops req after ack; with round-robin and all three re-requesting, grants rotate 001, 010, 100, 001.
REQ-038 draw_done never asserted, TIMEOUT=16 -> ack on cycle 16 of BUSY with err=1, then IDLE.
REQ-039 draw_done asserted in ISSUE only -> draw_done ignored; FSM stays in BUSY until a later draw_done.
REQ-040 reset pulsed in BUSY -> all outputs 0 immediately, no ack; a subsequent req=3'b100 is granted normally.
REQ-041 req_x changed from 120 to 126 during BUSY -> draw_x stays 120 until DONE.

Source files
------------

// File: rtl/draw_arb_pkg.sv
// Shared types and constants for the sprite-drawer arbiter.
// State encoding, requester indices and the default timeout live here.
package draw_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StBusy  = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [1:0] REQ_BG   = 2'd0;
  localparam logic [1:0] REQ_CHAR = 2'd1;
  localparam logic [1:0] REQ_PLAT = 2'd2;

  localparam int unsigned NUM_REQ         = 3;
  localparam int unsigned TIMEOUT_DEFAULT = 4096;

  // Next requester index, wrapping 2 -> 0.
  function automatic logic [1:0] idx_inc(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  function automatic logic [2:0] idx_onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/draw_arb_picker.sv
// Combinational winner selection for the three drawing requesters.
// DRAW_ARB_ROUND_ROBIN_EN selects round-robin from ptr; otherwise bit0 > bit1 > bit2.
module draw_arb_picker
  import draw_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] winner,
  output logic       valid
);

`ifdef DRAW_ARB_ROUND_ROBIN_EN
  always_comb begin : p_rr
    logic [1:0] idx;
    winner = REQ_BG;
    valid  = 1'b0;
    idx    = (ptr > 2'd2) ? 2'd0 : ptr;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!valid && req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
      idx = idx_inc(idx);
    end
  end
`else
  // Pointer is meaningless under fixed priority.
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    valid = |req;
    if (req[REQ_BG]) begin
      winner = REQ_BG;
    end else if (req[REQ_CHAR]) begin
      winner = REQ_CHAR;
    end else begin
      winner = REQ_PLAT;
    end
  end
`endif

endmodule

// File: rtl/draw_arbiter.sv
// Arbitrates three drawing requesters onto one sprite drawer with a BUSY timeout.
// Define DRAW_ARB_ROUND_ROBIN_EN for round-robin selection; default is fixed priority.
module draw_arbiter
  import draw_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned X_W     = 9,
  parameter int unsigned Y_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       req,
  input  logic [3*X_W-1:0] req_x,
  input  logic [3*Y_W-1:0] req_y,
  input  logic             draw_done,
  output logic [2:0]       grant,
  output logic [2:0]       ack,
  output logic             err,
  output logic             busy,
  output logic             draw_start,
  output logic [1:0]       draw_sel,
  output logic [X_W-1:0]   draw_x,
  output logic [Y_W-1:0]   draw_y
);

  localparam int unsigned   CntW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  state_e            state_q, state_d;
  logic [2:0]        grant_q, grant_d;
  logic [2:0]        ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;
  logic [1:0]        sel_q, sel_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [1:0] pick_ptr;
  logic [1:0] pick_idx;
  logic       pick_valid;

  draw_arb_picker u_picker (
    .req    (req),
    .ptr    (pick_ptr),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

`ifdef DRAW_ARB_ROUND_ROBIN_EN
  logic [1:0] rr_ptr_q, rr_ptr_d;

  // Pointer holds the index where the next search starts.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == StDone) begin
      rr_ptr_d = idx_inc(sel_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= 2'd0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign pick_ptr = rr_ptr_q;
`else
  assign pick_ptr = 2'd0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = 3'b000;
    err_d   = 1'b0;
    busy_d  = busy_q;
    start_d = 1'b0;
    sel_d   = sel_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StIssue;
          grant_d = idx_onehot(pick_idx);
          busy_d  = 1'b1;
          start_d = 1'b1;
          sel_d   = pick_idx;
          x_d     = req_x[pick_idx*X_W +: X_W];
          y_d     = req_y[pick_idx*Y_W +: Y_W];
          cnt_d   = '0;
        end
      end
      StIssue: begin
        state_d = StBusy;
      end
      StBusy: begin
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
        // draw_done takes precedence over a coincident timeout.
        if (draw_done) begin
          state_d = StDone;
          ack_d   = grant_q;
        end else if (cnt_q == CntLast) begin
          state_d = StDone;
          ack_d   = grant_q;
          err_d   = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        grant_d = 3'b000;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        grant_d = 3'b000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= 3'b000;
      ack_q   <= 3'b000;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      sel_q   <= 2'd0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      sel_q   <= sel_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant      = grant_q;
  assign ack        = ack_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign draw_start = start_q;
  assign draw_sel   = sel_q;
  assign draw_x     = x_q;
  assign draw_y     = y_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// Self-checking bench for draw_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of arbitration, timing and timeout.
module tb_draw_arbiter;

  localparam int TMO = 16;
  localparam int X_W = 9;
  localparam int Y_W = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic [2:0]       req;
  logic [3*X_W-1:0] req_x;
  logic [3*Y_W-1:0] req_y;
  logic             draw_done;
  logic [2:0]       grant;
  logic [2:0]       ack;
  logic             err;
  logic             busy;
  logic             draw_start;
  logic [1:0]       draw_sel;
  logic [X_W-1:0]   draw_x;
  logic [Y_W-1:0]   draw_y;

  int checks   = 0;
  int failures = 0;

`ifdef DRAW_ARB_ROUND_ROBIN_EN
  int rr_ptr = 0;
`endif

  draw_arbiter #(
    .TIMEOUT (TMO),
    .X_W     (X_W),
    .Y_W     (Y_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .draw_done  (draw_done),
    .grant      (grant),
    .ack        (ack),
    .err        (err),
    .busy       (busy),
    .draw_start (draw_start),
    .draw_sel   (draw_sel),
    .draw_x     (draw_x),
    .draw_y     (draw_y)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference winner: lowest set bit, or first set bit scanning from the RR pointer.
  function automatic int model_pick(input logic [2:0] r);
    int k;
    for (int i = 0; i < 3; i++) begin
`ifdef DRAW_ARB_ROUND_ROBIN_EN
      k = (rr_ptr + i) % 3;
`else
      k = i;
`endif
      if (r[k]) return k;
    end
    return 0;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_start"}, 32'(draw_start), 32'd0);
  endtask

  // Called at a negedge with the DUT in IDLE. done_after = BUSY cycle in which
  // draw_done is driven (0 = never). Returns the grant seen in ISSUE.
  task automatic do_txn(input logic [2:0] r, input int done_after, input bit done_in_issue,
                        input bit drop_mid, input bit move_x, output logic [2:0] g_obs);
    int             w;
    int             nbusy;
    logic           exp_err;
    logic [2:0]     oh;
    logic [X_W-1:0] ex;
    logic [Y_W-1:0] ey;
    req = r;
    w   = model_pick(r);
    oh  = 3'b000;
    oh[w] = 1'b1;
    ex  = req_x[w*X_W +: X_W];
    ey  = req_y[w*Y_W +: Y_W];
    if (done_after >= 1 && done_after <= TMO) begin
      nbusy   = done_after;
      exp_err = 1'b0;
    end else begin
      nbusy   = TMO;
      exp_err = 1'b1;
    end

    @(negedge clock);
    g_obs = grant;
    check("issue_grant", 32'(grant), 32'(oh));
    check("issue_start", 32'(draw_start), 32'd1);
    check("issue_sel", 32'(draw_sel), 32'(w));
    check("issue_x", 32'(draw_x), 32'(ex));
    check("issue_y", 32'(draw_y), 32'(ey));
    check("issue_busy", 32'(busy), 32'd1);
    check("issue_ack", 32'(ack), 32'd0);
    draw_done = done_in_issue;

    for (int k = 1; k <= nbusy; k++) begin
      @(negedge clock);
      check("busy_start", 32'(draw_start), 32'd0);
      check("busy_ack", 32'(ack), 32'd0);
      check("busy_grant", 32'(grant), 32'(oh));
      check("busy_x", 32'(draw_x), 32'(ex));
      check("busy_busy", 32'(busy), 32'd1);
      draw_done = (k == done_after);
      if (k == 1 && drop_mid) req = 3'b000;
      if (k == 1 && move_x) req_x[w*X_W +: X_W] = req_x[w*X_W +: X_W] + X_W'(6);
    end

    @(negedge clock);
    check("done_ack", 32'(ack), 32'(oh));
    check("done_err", 32'(err), 32'(exp_err));
    check("done_grant", 32'(grant), 32'(oh));
    check("done_sel", 32'(draw_sel), 32'(w));
    check("done_x", 32'(draw_x), 32'(ex));
    check("done_y", 32'(draw_y), 32'(ey));
    check("done_busy", 32'(busy), 32'd1);
    draw_done = 1'b0;
    req = req & ~oh;

    @(negedge clock);
    check_idle("post");
    check("post_err", 32'(err), 32'd0);
`ifdef DRAW_ARB_ROUND_ROBIN_EN
    rr_ptr = (w + 1) % 3;
`endif
  endtask

  logic [2:0] g;

  initial begin
    reset     = 1'b1;
    req       = 3'b000;
    req_x     = '0;
    req_y     = '0;
    draw_done = 1'b0;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check_idle("rst");
    check("rst_err", 32'(err), 32'd0);
    check("rst_sel", 32'(draw_sel), 32'd0);
    check("rst_x", 32'(draw_x), 32'd0);
    check("rst_y", 32'(draw_y), 32'd0);
    reset = 1'b0;

    // No request: stays idle
    repeat (3) begin
      @(negedge clock);
      check_idle("noreq");
    end

    // All three requesting, each dropping after its ack
`ifdef DRAW_ARB_ROUND_ROBIN_EN
    do_txn(3'b111, 2, 1'b0, 1'b0, 1'b0, g); check("rr_g0", 32'(g), 32'b001);
    do_txn(3'b111, 2, 1'b0, 1'b0, 1'b0, g); check("rr_g1", 32'(g), 32'b010);
    do_txn(3'b111, 2, 1'b0, 1'b0, 1'b0, g); check("rr_g2", 32'(g), 32'b100);
    do_txn(3'b111, 2, 1'b0, 1'b0, 1'b0, g); check("rr_g3", 32'(g), 32'b001);
`else
    do_txn(3'b111, 2, 1'b0, 1'b0, 1'b0, g); check("fp_g0", 32'(g), 32'b001);
    do_txn(3'b110, 2, 1'b0, 1'b0, 1'b0, g); check("fp_g1", 32'(g), 32'b010);
    do_txn(3'b100, 2, 1'b0, 1'b0, 1'b0, g); check("fp_g2", 32'(g), 32'b100);
`endif

    // Character at (95,221), draw_done 5 cycles after draw_start
    req_x[1*X_W +: X_W] = X_W'(95);
    req_y[1*Y_W +: Y_W] = Y_W'(221);
    do_txn(3'b010, 5, 1'b0, 1'b0, 1'b0, g);
    check("char_grant", 32'(g), 32'b010);

    // Timeout, tie between draw_done and timeout, draw_done only in ISSUE
    do_txn(3'b100, 0, 1'b0, 1'b0, 1'b0, g);
    do_txn(3'b001, TMO, 1'b0, 1'b0, 1'b0, g);
    do_txn(3'b010, 4, 1'b1, 1'b0, 1'b0, g);

    // req dropped mid-grant; req_x moved 120 -> 126 during BUSY
    do_txn(3'b001, 3, 1'b0, 1'b1, 1'b0, g);
    req_x[2*X_W +: X_W] = X_W'(120);
    do_txn(3'b100, 4, 1'b0, 1'b0, 1'b1, g);
    check("move_src", 32'(req_x[2*X_W +: X_W]), 32'd126);

    // Reset during BUSY abandons the grant
    req = 3'b010;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    req   = 3'b000;
    #1;
    check_idle("mid_rst");
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_sel", 32'(draw_sel), 32'd0);
    check("mid_rst_x", 32'(draw_x), 32'd0);
    @(negedge clock);
    check("mid_rst_ack", 32'(ack), 32'd0);
    reset = 1'b0;
`ifdef DRAW_ARB_ROUND_ROBIN_EN
    rr_ptr = 0;
`endif
    @(negedge clock);
    check_idle("after_rst");
    do_txn(3'b100, 3, 1'b0, 1'b0, 1'b0, g);
    check("after_rst_grant", 32'(g), 32'b100);

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 3; k++) begin
        req_x[k*X_W +: X_W] = X_W'($urandom_range(0, 319));
        req_y[k*Y_W +: Y_W] = Y_W'($urandom_range(0, 239));
      end
      do_txn(3'($urandom_range(1, 7)), int'($urandom_range(0, 20)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
